// File: rtl/dbg_disp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dbg_disp_pkg
// Description : Shared constants for the pipeline debug-overlay text scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package dbg_disp_pkg;

  localparam int STATE_W = 2;
  localparam logic [STATE_W-1:0] ST_IDLE   = 2'd0;
  localparam logic [STATE_W-1:0] ST_DECODE = 2'd1;
  localparam logic [STATE_W-1:0] ST_WRITE  = 2'd2;
  localparam logic [STATE_W-1:0] ST_DONE   = 2'd3;

  localparam logic [7:0]  ASCII_SPACE = 8'h20;
  // Right-aligned with leading NULs, matching the decoder's own padding.
  localparam logic [79:0] BUBBLE_STR  = {32'h0, "BUBBLE"};

  localparam int STAGE_IF  = 0;
  localparam int STAGE_ID  = 1;
  localparam int STAGE_EX  = 2;
  localparam int STAGE_MEM = 3;
  localparam int STAGE_WB  = 4;

  function automatic logic [7:0] disp_char(input logic [7:0] c);
    return (c == 8'h00) ? ASCII_SPACE : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/decode_display_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : decode_display_sched_if
// Description : Text RAM write channel (request held until txt_ready).
// Revision    : 1.0 - initial release
// ============================================================================
interface decode_display_sched_if #(
  parameter int ADDR_W = 11
) ();

  logic              txt_we;
  logic [ADDR_W-1:0] txt_addr;
  logic [7:0]        txt_data;
  logic              txt_ready;

  modport master (output txt_we, output txt_addr, output txt_data, input txt_ready);
  modport slave  (input txt_we, input txt_addr, input txt_data, output txt_ready);

endinterface
`default_nettype wire

// File: rtl/decode_display_sched.sv
`default_nettype none
// ============================================================================
// Module      : decode_display_sched
// Description : Time-shares one instruction decoder across all pipeline stages
//               and streams the mnemonics into the VGA text RAM each frame.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_display_sched
  import dbg_disp_pkg::*;
#(
  parameter int NSTAGES   = 5,
  parameter int STR_CHARS = 10,
  parameter int COLS      = 40,
  parameter int ROW_BASE  = 0,
  parameter int COL_BASE  = 0,
  parameter int ADDR_W    = 11
) (
  input  wire logic                   clk,
  input  wire logic                   reset,
  input  wire logic                   frame_start,
  input  wire logic [32*NSTAGES-1:0]  stage_instr,
  input  wire logic [NSTAGES-1:0]     stage_valid,
  output logic      [31:0]            dec_instr,
  input  wire logic [8*STR_CHARS-1:0] dec_str,
  decode_display_sched_if.master      txt,
  output logic                        busy,
  output logic                        done,
  output logic      [7:0]             overrun_cnt
);

  localparam int STR_W  = 8 * STR_CHARS;
  localparam int IDX_W  = (NSTAGES > 1) ? $clog2(NSTAGES) : 1;
  localparam int CIDX_W = (STR_CHARS > 1) ? $clog2(STR_CHARS) : 1;

  localparam logic [ADDR_W-1:0] c_row0_addr = ADDR_W'(ROW_BASE * COLS + COL_BASE);
  localparam logic [ADDR_W-1:0] c_cols      = ADDR_W'(COLS);
  localparam logic [IDX_W-1:0]  c_last_idx  = IDX_W'(NSTAGES - 1);
  localparam logic [CIDX_W-1:0] c_last_cidx = CIDX_W'(STR_CHARS - 1);

  logic [STATE_W-1:0]    r_state;
  logic [STATE_W-1:0]    w_next;
  logic [32*NSTAGES-1:0] r_snap_instr;
  logic [NSTAGES-1:0]    r_snap_valid;
  logic [IDX_W-1:0]      r_idx;
  logic [CIDX_W-1:0]     r_cidx;
  logic [STR_W-1:0]      r_str;
  logic [ADDR_W-1:0]     r_row_addr;
  logic [31:0]           r_dec_hold;
  logic [7:0]            r_overrun;

  logic w_accept;
  logic w_last_char;
  logic w_last_stage;

  assign w_accept     = (r_state == ST_WRITE) && txt.txt_ready;
  assign w_last_char  = (r_cidx == c_last_cidx);
  assign w_last_stage = (r_idx == c_last_idx);
  assign overrun_cnt  = r_overrun;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (frame_start) w_next = ST_DECODE;
      ST_DECODE: w_next = ST_WRITE;
      ST_WRITE:  if (w_accept && w_last_char) w_next = w_last_stage ? ST_DONE : ST_DECODE;
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // The snapshot and string registers shift rather than index, so the current
  // stage and current char always sit at a fixed position.
  always_comb begin
    busy         = (r_state != ST_IDLE);
    done         = (r_state == ST_DONE);
    dec_instr    = r_dec_hold;
    txt.txt_we   = 1'b0;
    txt.txt_addr = '0;
    txt.txt_data = '0;
    if (r_state == ST_DECODE && r_snap_valid[0]) dec_instr = r_snap_instr[31:0];
    if (r_state == ST_WRITE) begin
      txt.txt_we   = 1'b1;
      txt.txt_addr = r_row_addr + ADDR_W'(r_cidx);
      txt.txt_data = disp_char(r_str[STR_W-1 -: 8]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_snap_instr <= '0;
      r_snap_valid <= '0;
      r_idx        <= '0;
      r_cidx       <= '0;
      r_str        <= '0;
      r_row_addr   <= '0;
      r_dec_hold   <= '0;
      r_overrun    <= '0;
    end else begin
      r_dec_hold <= dec_instr;
      if (frame_start && r_state != ST_IDLE && r_overrun != 8'hFF)
        r_overrun <= r_overrun + 8'd1;
      case (r_state)
        ST_IDLE: begin
          if (frame_start) begin
            r_snap_instr <= stage_instr;
            r_snap_valid <= stage_valid;
            r_idx        <= IDX_W'(STAGE_IF);
            r_row_addr   <= c_row0_addr;
          end
        end
        ST_DECODE: begin
          r_str  <= r_snap_valid[0] ? dec_str : STR_W'(BUBBLE_STR);
          r_cidx <= '0;
        end
        ST_WRITE: begin
          if (w_accept) begin
            r_str  <= r_str << 8;
            r_cidx <= r_cidx + CIDX_W'(1);
            if (w_last_char && !w_last_stage) begin
              r_idx        <= r_idx + IDX_W'(1);
              r_row_addr   <= r_row_addr + c_cols;
              r_snap_instr <= r_snap_instr >> 32;
              r_snap_valid <= r_snap_valid >> 1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_decode_display_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_display_sched
// Description : Directed/randomized bench with a stand-in decoder and a
//               string-level reference model of the expected text RAM writes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_display_sched;

  logic         clk = 1'b0;
  logic         reset;
  logic         frame_start;
  logic [159:0] stage_instr;
  logic [4:0]   stage_valid;
  logic [31:0]  dec_instr;
  logic [79:0]  dec_str;
  logic         txt_ready;
  logic         busy;
  logic         done;
  logic [7:0]   overrun_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  decode_display_sched_if #(.ADDR_W(11)) txt_if ();
  assign txt_if.txt_ready = txt_ready;

  decode_display_sched #(
    .NSTAGES(5), .STR_CHARS(10), .COLS(40), .ROW_BASE(0), .COL_BASE(0), .ADDR_W(11)
  ) dut (
    .clk(clk),
    .reset(reset),
    .frame_start(frame_start),
    .stage_instr(stage_instr),
    .stage_valid(stage_valid),
    .dec_instr(dec_instr),
    .dec_str(dec_str),
    .txt(txt_if),
    .busy(busy),
    .done(done),
    .overrun_cnt(overrun_cnt)
  );

  // Stand-in for the external decoder: a fixed mnemonic table keyed on instr.
  function automatic logic [79:0] ref_decode(input logic [31:0] ins);
    if (ins == 32'h0000_0033) return {56'h0, "ADD"};
    case (ins[2:0])
      3'd0:    return {56'h0, "SUB"};
      3'd1:    return {48'h0, "ADDI"};
      3'd2:    return {64'h0, "LW"};
      3'd3:    return {64'h0, "SW"};
      3'd4:    return {56'h0, "BEQ"};
      3'd5:    return {56'h0, "JAL"};
      3'd6:    return {40'h0, "SLTIU"};
      default: return {8'h0, "FENCE.TSO"};
    endcase
  endfunction

  always_comb dec_str = ref_decode(dec_instr);

  // Negedge monitor: accepted writes, stall stability, watched dec_instr hits.
  logic [18:0] wq[$];
  int          stall_err = 0;
  int          hits      = 0;
  logic [31:0] watch     = 32'h0;
  bit          watch_en  = 1'b0;
  logic        p_stall   = 1'b0;
  logic [10:0] p_addr    = '0;
  logic [7:0]  p_data    = '0;

  always @(negedge clk) begin
    if (txt_if.txt_we && txt_ready && !reset) wq.push_back({txt_if.txt_addr, txt_if.txt_data});
    if (p_stall && (!txt_if.txt_we || txt_if.txt_addr != p_addr || txt_if.txt_data != p_data))
      stall_err <= stall_err + 1;
    p_stall <= txt_if.txt_we && !txt_ready && !reset;
    p_addr  <= txt_if.txt_addr;
    p_data  <= txt_if.txt_data;
    if (watch_en && busy && dec_instr === watch) hits <= hits + 1;
  end

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [18:0] exp_q[$];

  // Whole refresh as a list of (address, char) pairs, row s = stage s.
  function automatic void build_exp(input logic [159:0] ins, input logic [4:0] vl);
    logic [79:0] s;
    logic [7:0]  ch;
    exp_q.delete();
    for (int st = 0; st < 5; st++) begin
      s = vl[st] ? ref_decode(ins[32*st +: 32]) : {32'h0, "BUBBLE"};
      for (int c = 0; c < 10; c++) begin
        ch = s[79-8*c -: 8];
        if (ch == 8'h00) ch = 8'h20;
        exp_q.push_back({11'(st*40 + c), ch});
      end
    end
  endfunction

  task automatic check_writes(input string tag, input int start, input logic [159:0] ins,
                              input logic [4:0] vl);
    int          bad = -1;
    int          idx;
    logic [18:0] got;
    build_exp(ins, vl);
    chk({tag, "_count"}, 80'(wq.size() - start), 80'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (start + i < wq.size()) ? wq[start+i] : 19'h7FFFF;
      if (got !== exp_q[i] && bad < 0) bad = i;
    end
    idx = (bad < 0) ? 0 : bad;
    got = (start + idx < wq.size()) ? wq[start+idx] : 19'h7FFFF;
    chk({tag, "_seq"}, 80'(got), 80'(exp_q[idx]));
  endtask

  function automatic logic [79:0] row_text(input int start, input int off);
    logic [79:0] r = '0;
    for (int c = 0; c < 10; c++)
      r = {r[71:0], (start + off + c < wq.size()) ? wq[start+off+c][7:0] : 8'h3F};
    return r;
  endfunction

  function automatic logic [159:0] rand_instrs();
    return {$urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // One refresh: pulse frame_start, then step cycles (k=1 is the first cycle
  // after the capturing edge) until done, an optional reset cycle, or timeout.
  task automatic run(input logic [159:0] ins, input logic [4:0] vl, input bit rnd,
                     input int inj_k, input bit inj_done, input int rst_k,
                     output int done_k, output int busy_n);
    bit fin = 1'b0;
    done_k = -1;
    busy_n = 0;
    @(posedge clk); #1;
    stage_instr = ins; stage_valid = vl; frame_start = 1'b1; txt_ready = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    stage_instr = rand_instrs();
    stage_valid = ~vl;
    for (int k = 1; k <= 3000 && !fin; k++) begin
      txt_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (busy) busy_n++;
      if (done) begin
        done_k = k;
        fin = 1'b1;
        if (inj_done) frame_start = 1'b1;
      end
      if (k == inj_k) begin
        frame_start = 1'b1;
        stage_instr = rand_instrs();
      end
      if (k == rst_k) begin
        reset = 1'b1;
        fin = 1'b1;
      end
      @(posedge clk); #1;
      frame_start = 1'b0;
    end
    txt_ready = 1'b1;
  endtask

  initial begin
    logic [159:0] ins;
    logic [4:0]   vl;
    int           st, dk, bn, h0, se0, k;

    reset = 1'b1; frame_start = 1'b0; stage_instr = '0; stage_valid = '0; txt_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_we_busy_done", {busy, done, txt_if.txt_we}, 80'h0);
    chk("reset_overrun", 80'(overrun_cnt), 80'h0);
    chk("reset_dec_instr", 80'(dec_instr), 80'h0);
    chk("reset_addr_data", {txt_if.txt_addr, txt_if.txt_data}, 80'h0);
    reset = 1'b0;

    // Test 1: IF = ADD, all valid, ready high.
    ins = rand_instrs();
    ins[31:0] = 32'h0000_0033;
    st = wq.size();
    run(ins, 5'b11111, 1'b0, -1, 1'b0, -1, dk, bn);
    chk("t1_done_cycle", 80'(dk), 80'd56);
    chk("t1_busy_cycles", 80'(bn), 80'd56);
    chk("t1_row0", row_text(st, 0), "       ADD");
    check_writes("t1", st, ins, 5'b11111);

    // Test 2: EX is a bubble and its instr must never reach the decoder.
    do ins = rand_instrs();
    while (ins[95:64] == ins[31:0] || ins[95:64] == ins[63:32] || ins[95:64] == ins[127:96] ||
           ins[95:64] == ins[159:128] || ins[95:64] == dec_instr);
    watch = ins[95:64]; watch_en = 1'b1; h0 = hits;
    st = wq.size();
    run(ins, 5'b11011, 1'b0, -1, 1'b0, -1, dk, bn);
    @(negedge clk);
    watch_en = 1'b0;
    chk("t2_ex_not_decoded", 80'(hits - h0), 80'd0);
    chk("t2_row2", row_text(st, 20), "    BUBBLE");
    chk("t2_row2_addr", 80'((st + 20 < wq.size()) ? wq[st+20][18:8] : 11'h7FF), 80'd80);
    check_writes("t2", st, ins, 5'b11011);

    // Test 3: random back-pressure.
    ins = rand_instrs();
    vl  = 5'($urandom_range(0, 31));
    se0 = stall_err;
    st  = wq.size();
    run(ins, vl, 1'b1, -1, 1'b0, -1, dk, bn);
    chk("t3_done_seen", 80'(dk > 0), 80'd1);
    check_writes("t3", st, ins, vl);
    chk("t3_stall_stable", 80'(stall_err - se0), 80'd0);

    // Test 4: frame_starts at cycle 20 and in the DONE cycle are dropped.
    ins = rand_instrs();
    vl  = 5'b10111;
    st  = wq.size();
    run(ins, vl, 1'b0, 20, 1'b1, -1, dk, bn);
    chk("t4_overrun", 80'(overrun_cnt), 80'd2);
    check_writes("t4", st, ins, vl);
    repeat (3) @(posedge clk);
    #1;
    chk("t4_no_restart", 80'(busy), 80'd0);

    // Test 5: reset mid-WRITE aborts, then a fresh refresh starts at row0 col0.
    ins = rand_instrs();
    run(ins, 5'b11111, 1'b0, -1, 1'b0, 30, dk, bn);
    chk("t5_abort_we_busy", {txt_if.txt_we, busy}, 80'h0);
    chk("t5_abort_overrun", 80'(overrun_cnt), 80'h0);
    reset = 1'b0;
    ins = rand_instrs();
    vl  = 5'($urandom_range(0, 31));
    st  = wq.size();
    run(ins, vl, 1'b0, -1, 1'b0, -1, dk, bn);
    chk("t5_first_addr", 80'((st < wq.size()) ? wq[st][18:8] : 11'h7FF), 80'd0);
    check_writes("t5", st, ins, vl);

    // Test 6: hold the RAM off and flood frame_start; overrun must saturate.
    ins = rand_instrs();
    vl  = 5'b11111;
    se0 = stall_err;
    st  = wq.size();
    @(posedge clk); #1;
    stage_instr = ins; stage_valid = vl; frame_start = 1'b1; txt_ready = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      @(posedge clk); #1;
      if (i == 11) chk("t6_overrun_10", 80'(overrun_cnt), 80'd10);
      frame_start = 1'b1;
    end
    @(posedge clk); #1;
    frame_start = 1'b0;
    chk("t6_overrun_sat", 80'(overrun_cnt), 80'd255);
    chk("t6_still_busy_no_write", {busy, 8'(wq.size() - st)}, {1'b1, 8'd0});
    txt_ready = 1'b1;
    k = 0;
    while (!done && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    chk("t6_done_seen", 80'(done), 80'd1);
    @(posedge clk); #1;
    check_writes("t6", st, ins, vl);
    chk("t6_stall_stable", 80'(stall_err - se0), 80'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
